uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered, parametrised UART transmitter replacing the single-slot `uart_tx` path behind the memory-mapped TX register. CPU stores are queued in a DEPTH-entry FIFO and serialised on `tx` without stalling the pipeline. A sticky overflow flag and a fill level are exposed for software polling through `memory`.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: input clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate. `CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE` (integer divide), must be ≥ 2.
- `DEPTH`, default 8: FIFO entries. Must be a power of two, ≥ 2.
- `DATA_BITS`, default 8: bits per character, 5–9.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `clk_enable` in 1: pipeline clock enable; qualifies writes only.
- `wr_en` in 1: enqueue request.
- `wr_data` in DATA_BITS: character to enqueue.
- `full` out 1: FIFO holds DEPTH entries.
- `level` out $clog2(DEPTH)+1: number of queued entries, excluding the frame on the line.
- `busy` out 1: high when the FSM is not IDLE or `level` != 0.
- `overflow` out 1: sticky; set by a write dropped while full. Cleared only by reset.
- `tx` out 1: serial line, idle high.

## Operation
- A write is accepted when `wr_en & clk_enable & ~full`. `full` is sampled before any same-cycle pop, so a write on a full FIFO is dropped even if a pop occurs that cycle. A dropped write sets `overflow`.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - full = MSBs differ and the rest are equal.
  - empty = pointers equal.
- A simultaneous accepted write and pop leaves `level` unchanged.
- FSM states: IDLE, START, DATA, STOP (PARITY is added when the configuration macro is defined).
  - IDLE → START when the FIFO is non-empty. This transition pops the head entry into the shift register.
  - START drives 0 for one bit time, then → DATA.
  - DATA drives the shift register LSB first, DATA_BITS bit times, then → STOP.
  - STOP drives 1 for one bit time. At the end of STOP:
    - FIFO non-empty → START directly, with the pop; there is no idle gap.
    - FIFO empty → IDLE.
- The baud counter runs every `clk` cycle, independent of `clk_enable`, so line timing is real-time. The counter restarts at 0 on each state entry.
- Reset mid-frame: the frame is aborted and `tx` returns to 1 on the next edge. The FIFO is emptied, the FSM goes to IDLE, and `overflow` is cleared.
- `wr_data` is ignored when `wr_en` is low. Unused storage is never read.

## Timing
- Reset values: `tx`=1, `full`=0, `level`=0, `busy`=0, `overflow`=0.
- A write accepted at edge N (FIFO empty, IDLE):
  - `level`=1 is visible after N.
  - The pop and START entry occur at edge N+1, so `level` returns to 0.
  - `tx` falls after edge N+1, a latency of 2 cycles from the `wr_en` edge.
- Each bit lasts exactly CYCLES_PER_BIT cycles. A frame lasts (DATA_BITS+2)·CYCLES_PER_BIT cycles, plus one bit time with parity.
- `full` and `level` update in the cycle after the accepting or popping edge. They are registered outputs with no combinational path from `wr_en`.
- `busy` falls in the cycle after the last stop bit completes, if the FIFO is empty.

## Configuration
- `UART_TX_FIFO_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. It drives even parity, the XOR of the DATA_BITS data bits, for one bit time. Frame length is DATA_BITS+3 bits.
- Not defined: no parity state; frame is DATA_BITS+2 bits (8N1 at the default).

## Test plan
Configuration for all scenarios: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 cycles/bit), DEPTH=4, DATA_BITS=8.
- Single byte: write 0xA5 once → after 2 cycles, `tx` sequence (10 cycles each) is 0,1,0,1,0,0,1,0,1,1. `busy` drops 1 cycle after the stop bit. Total 100 line cycles.
- Back-to-back: write 0x00,0xFF,0x55 on consecutive enabled cycles → three frames with no idle gap. `level` peaks at 2 and returns to 0 after the third pop.
- Overflow: hold `tx` traffic, write 6 bytes in 6 consecutive cycles →
  - 5 accepted (1 on the line, 4 queued); `full`=1.
  - The 6th is dropped and `overflow`=1, which stays 1 after the FIFO drains.
- Full plus pop collision: with the FIFO full, write in the same cycle as the STOP→START pop → write dropped, `overflow` set, `level` goes 4→3.
- `clk_enable` gating: `wr_en`=1 with `clk_enable`=0 for 5 cycles → no entries and `tx` stays 1. An in-flight frame keeps 10-cycle bit timing while `clk_enable` toggles.
- Reset mid-frame (and, with parity enabled, byte 0x07 gives parity bit 1):
  - Assert `reset` in DATA bit 3 → `tx`=1, `level`=0, `busy`=0 after one edge.
  - A new write afterwards produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : FIFO-buffered UART transmitter with sticky overflow and fill level.
//               Define UART_TX_FIFO_PARITY_EN to add an even-parity bit per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DEPTH     = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_enable,
    input  logic                   wr_en,
    input  logic [DATA_BITS-1:0]   wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   overflow,
    output logic                   tx
);

    localparam int c_CPB   = CLK_FREQ / BAUD_RATE;
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_PW    = c_AW + 1;
    localparam int c_CNT_W = (c_CPB > 1) ? $clog2(c_CPB) : 1;
    localparam int c_BIT_W = $clog2(DATA_BITS);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_TX_FIFO_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [c_AW:0]        r_wr_ptr;
    logic [c_AW:0]        r_rd_ptr;
    logic [c_AW:0]        w_wr_ptr_nxt;
    logic [c_AW:0]        w_rd_ptr_nxt;
    logic [c_AW:0]        r_level;
    logic                 r_full;
    logic                 r_overflow;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [c_CNT_W-1:0]   r_baud_cnt;
    logic                 w_bit_done;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic                 w_last_bit;
    logic [DATA_BITS-1:0] r_shift;
`ifdef UART_TX_FIFO_PARITY_EN
    logic                 r_parity;
`endif

    // full is registered, so a write is judged against the pre-pop occupancy
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_push     = wr_en & clk_enable & ~r_full;
    assign w_drop     = wr_en & clk_enable & r_full;
    assign w_bit_done = (r_baud_cnt == c_CNT_W'(c_CPB - 1));
    assign w_last_bit = (r_bit_cnt == c_BIT_W'(DATA_BITS - 1));
    assign w_pop      = ~w_empty & ((r_state == c_ST_IDLE) |
                                    ((r_state == c_ST_STOP) & w_bit_done));

    assign w_wr_ptr_nxt = w_push ? r_wr_ptr + c_PW'(1) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? r_rd_ptr + c_PW'(1) : r_rd_ptr;

    assign full     = r_full;
    assign level    = r_level;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
            r_full   <= (w_wr_ptr_nxt[c_AW] != w_rd_ptr_nxt[c_AW]) &&
                        (w_wr_ptr_nxt[c_AW-1:0] == w_rd_ptr_nxt[c_AW-1:0]);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Baud counter free-runs on clk; every state entry coincides with a bit boundary
    always_ff @(posedge clk) begin
        if (reset || r_state == c_ST_IDLE || w_bit_done) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef UART_TX_FIFO_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr[c_AW-1:0]];
            r_bit_cnt <= '0;
`ifdef UART_TX_FIFO_PARITY_EN
            r_parity  <= ^r_mem[r_rd_ptr[c_AW-1:0]];
`endif
        end else if (r_state == c_ST_DATA && w_bit_done) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) w_state_nxt = c_ST_START;
            end
            c_ST_START: begin
                if (w_bit_done) w_state_nxt = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_bit_done && w_last_bit) begin
`ifdef UART_TX_FIFO_PARITY_EN
                    w_state_nxt = c_ST_PARITY;
`else
                    w_state_nxt = c_ST_STOP;
`endif
                end
            end
`ifdef UART_TX_FIFO_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_done) w_state_nxt = c_ST_STOP;
            end
`endif
            c_ST_STOP: begin
                if (w_bit_done) w_state_nxt = w_empty ? c_ST_IDLE : c_ST_START;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            c_ST_START:  tx = 1'b0;
            c_ST_DATA:   tx = r_shift[0];
`ifdef UART_TX_FIFO_PARITY_EN
            c_ST_PARITY: tx = r_parity;
`endif
            default:     tx = 1'b1;
        endcase
        busy = (r_state != c_ST_IDLE) || (r_level != '0);
    end

endmodule
`default_nettype wire
